// File: rtl/player_motion_fsm_if.sv
// Player controller bundle: debounced buttons, physics strobe and crash flag toward the FSM,
// height, game-state pulses and jump/duck status back toward renderer and collision logic.
interface player_motion_fsm_if #(
    parameter int unsigned POS_W = 6,
    parameter int unsigned JL_W  = 2
);
    logic             physics_tick;
    logic             button_up;
    logic             button_down;
    logic             crash;
    logic [POS_W-1:0] player_position;
    logic             game_start_pulse;
    logic             game_over_pulse;
    logic             jump_pulse;
    logic             jumping;
    logic             ducking;
    logic [JL_W-1:0]  jumps_left;

    modport master (
        output physics_tick, button_up, button_down, crash,
        input  player_position, game_start_pulse, game_over_pulse, jump_pulse, jumping, ducking,
               jumps_left
    );

    modport slave (
        input  physics_tick, button_up, button_down, crash,
        output player_position, game_start_pulse, game_over_pulse, jump_pulse, jumping, ducking,
               jumps_left
    );
endinterface

// File: rtl/player_motion_fsm.sv
// Player motion controller: signed-velocity physics with gravity, hold-to-extend jump,
// multi-jump, fast-fall, crash handling and restart.
module player_motion_fsm #(
    parameter int unsigned POS_W      = 6,
    parameter int unsigned VEL_W      = 6,
    parameter int unsigned JUMP_VEL   = 7,
    parameter int unsigned GRAVITY    = 1,
    parameter int unsigned MAX_JUMPS  = 2,
    parameter int unsigned HOLD_TICKS = 2,
    parameter bit          FAST_FALL  = 1'b1
) (
    input logic               clk,
    input logic               reset_n,
    player_motion_fsm_if.slave pm
);
    localparam int unsigned JlW   = $clog2(MAX_JUMPS + 1);
    localparam int unsigned HoldW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam int unsigned SumW  = ((POS_W > VEL_W) ? POS_W : VEL_W) + 2;

    localparam logic signed [VEL_W-1:0] JumpVel  = VEL_W'(JUMP_VEL);
    localparam logic signed [VEL_W-1:0] VelMin   = {1'b1, {(VEL_W-1){1'b0}}};
    localparam logic signed [VEL_W+1:0] VelMinW  = {3'b111, {(VEL_W-1){1'b0}}};
    localparam logic signed [VEL_W+1:0] Grav     = (VEL_W+2)'(GRAVITY);
    localparam logic signed [VEL_W+1:0] GravDbl  = (VEL_W+2)'(2 * GRAVITY);
    localparam logic signed [SumW-1:0]  PosMaxS  = SumW'(2 ** POS_W - 1);
    localparam logic [POS_W-1:0]        PosMax   = {POS_W{1'b1}};
    localparam logic [HoldW-1:0]        HoldInit = HoldW'(HOLD_TICKS);
    localparam logic [JlW-1:0]          JlMax    = JlW'(MAX_JUMPS);

    typedef enum logic [1:0] {StIdle, StRun, StAir, StDead} state_e;

    state_e                   state_q;
    logic [POS_W-1:0]         pos_q;
    logic signed [VEL_W-1:0]  vel_q;
    logic [HoldW-1:0]         hold_q;
    logic [JlW-1:0]           jumps_q;
    logic                     up_prev_q;
    logic                     start_q;
    logic                     over_q;
    logic                     jump_q;

    logic                     up_rise;
    logic                     hold_active;
    logic signed [SumW-1:0]   new_pos;
    logic signed [VEL_W+1:0]  grav_step;
    logic signed [VEL_W+1:0]  vel_wide;
    logic signed [VEL_W-1:0]  vel_next;
    logic [HoldW-1:0]         hold_next;
    logic                     hit_ceil;
    logic                     hit_ground;
    logic [POS_W-1:0]         pos_phys;
    logic signed [VEL_W-1:0]  vel_phys;

    always_comb begin
        up_rise     = pm.button_up & ~up_prev_q;
        hold_active = (hold_q != '0) && pm.button_up;
        new_pos     = $signed({{(SumW-POS_W){1'b0}}, pos_q}) +
                      $signed({{(SumW-VEL_W){vel_q[VEL_W-1]}}, vel_q});
        grav_step   = (FAST_FALL && pm.button_down) ? GravDbl : Grav;
        vel_wide    = $signed({{2{vel_q[VEL_W-1]}}, vel_q}) - grav_step;
        vel_next    = vel_q;
        hold_next   = '0;
        if (hold_active) begin
            hold_next = hold_q - 1'b1;
        end else if (vel_wide < VelMinW) begin
            vel_next = VelMin;
        end else begin
            vel_next = vel_wide[VEL_W-1:0];
        end
        hit_ceil   = (new_pos >= PosMaxS);
        hit_ground = (new_pos <= 0);
        pos_phys   = new_pos[POS_W-1:0];
        vel_phys   = vel_next;
        // Ceiling kills upward speed but lets gravity pull the player off the ceiling.
        if (hit_ceil) begin
            pos_phys = PosMax;
            vel_phys = vel_next[VEL_W-1] ? vel_next : '0;
        end else if (hit_ground) begin
            pos_phys = '0;
            vel_phys = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            pos_q     <= '0;
            vel_q     <= '0;
            hold_q    <= '0;
            jumps_q   <= JlMax;
            up_prev_q <= 1'b0;
            start_q   <= 1'b0;
            over_q    <= 1'b0;
            jump_q    <= 1'b0;
        end else begin
            up_prev_q <= pm.button_up;
            start_q   <= 1'b0;
            over_q    <= 1'b0;
            jump_q    <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (up_rise) begin
                        state_q <= StRun;
                        start_q <= 1'b1;
                    end
                end
                StRun: begin
                    if (pm.crash) begin
                        state_q <= StDead;
                        over_q  <= 1'b1;
                    end else if (up_rise) begin
                        state_q <= StAir;
                        vel_q   <= JumpVel;
                        hold_q  <= HoldInit;
                        jumps_q <= JlMax - 1'b1;
                        jump_q  <= 1'b1;
                    end
                end
                StAir: begin
                    if (pm.crash) begin
                        state_q <= StDead;
                        over_q  <= 1'b1;
                    end else begin
                        if (pm.physics_tick) begin
                            pos_q  <= pos_phys;
                            vel_q  <= vel_phys;
                            hold_q <= hold_next;
                            if (hit_ground) begin
                                state_q <= StRun;
                                jumps_q <= JlMax;
                            end
                        end
                        // A mid-air jump wins over a same-tick landing: stay airborne at pos 0.
                        if (up_rise && jumps_q != '0) begin
                            state_q <= StAir;
                            vel_q   <= JumpVel;
                            hold_q  <= HoldInit;
                            jumps_q <= jumps_q - 1'b1;
                            jump_q  <= 1'b1;
                        end
                    end
                end
                StDead: begin
                    if (up_rise) begin
                        state_q <= StRun;
                        pos_q   <= '0;
                        vel_q   <= '0;
                        hold_q  <= '0;
                        jumps_q <= JlMax;
                        start_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign pm.player_position  = pos_q;
    assign pm.game_start_pulse = start_q;
    assign pm.game_over_pulse  = over_q;
    assign pm.jump_pulse       = jump_q;
    assign pm.jumping          = (state_q == StAir);
    assign pm.ducking          = (state_q == StRun) && pm.button_down;
    assign pm.jumps_left       = jumps_q;
endmodule

// File: tb/tb_player_motion_fsm.sv
// Directed bench for player_motion_fsm: expectations queued with each stimulus step and
// compared once the step's clock edge has passed.
module tb_player_motion_fsm;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];

    player_motion_fsm_if #(.POS_W(6), .JL_W(2)) bus ();
    player_motion_fsm_if #(.POS_W(4), .JL_W(2)) bus4 ();

    player_motion_fsm dut (.clk(clk), .reset_n(reset_n), .pm(bus));
    player_motion_fsm #(.POS_W(4)) dut4 (.clk(clk), .reset_n(reset_n), .pm(bus4));

    always #5 clk = ~clk;

    task automatic want(input string tag, input logic [31:0] exp);
        sb.push_back('{tag, exp});
    endtask

    task automatic got(input logic [31:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.exp);
        end
    endtask

    task automatic cyc(input logic tick, input logic up, input logic down, input logic cr);
        bus.physics_tick = tick;
        bus.button_up    = up;
        bus.button_down  = down;
        bus.crash        = cr;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc4(input logic tick, input logic up);
        bus4.physics_tick = tick;
        bus4.button_up    = up;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int single_tbl[15] = '{7, 13, 18, 22, 25, 27, 28, 28, 27, 25, 22, 18, 13, 7, 0};
        int hold_tbl[10]   = '{7, 14, 21, 27, 32, 36, 39, 41, 42, 42};
        int dj_tbl[3]      = '{35, 41, 46};
        int ff_tbl[10]     = '{50, 52, 52, 50, 46, 40, 32, 22, 10, 0};
        int p4_tbl[5]      = '{7, 13, 15, 15, 14};

        bus.physics_tick  = 1'b0; bus.button_up  = 1'b0; bus.button_down  = 1'b0; bus.crash  = 1'b0;
        bus4.physics_tick = 1'b0; bus4.button_up = 1'b0; bus4.button_down = 1'b0; bus4.crash = 1'b0;

        // Reset values
        want("rst_pos", 0); want("rst_jl", 2); want("rst_jumping", 0); want("rst_start", 0);
        repeat (2) @(posedge clk);
        #1;
        got(bus.player_position); got(bus.jumps_left); got(bus.jumping); got(bus.game_start_pulse);
        reset_n = 1'b1;

        // Start: pulse, no jump
        want("start_pulse", 1); want("start_nojump", 0); want("start_pos", 0);
        cyc(0, 1, 0, 0);
        got(bus.game_start_pulse); got(bus.jump_pulse); got(bus.player_position);
        want("start_once", 0); want("run_not_air", 0);
        cyc(0, 0, 0, 0);
        got(bus.game_start_pulse); got(bus.jumping);

        // Duck, then jump overriding duck
        want("duck_run", 1);
        cyc(0, 0, 1, 0);
        got(bus.ducking);
        want("jump_pulse", 1); want("jump_air", 1); want("jump_jl", 1); want("jump_unduck", 0);
        cyc(0, 1, 1, 0);
        got(bus.jump_pulse); got(bus.jumping); got(bus.jumps_left); got(bus.ducking);
        want("jump_once", 0);
        cyc(0, 0, 0, 0);
        got(bus.jump_pulse);

        // Single jump, released before first tick
        for (int i = 0; i < 15; i++) begin
            want($sformatf("single_t%0d", i + 1), single_tbl[i]);
            if (i == 14) begin
                want("single_land_air", 0); want("single_land_jl", 2);
            end
            cyc(1, 0, 0, 0);
            got(bus.player_position);
            if (i == 14) begin
                got(bus.jumping); got(bus.jumps_left);
            end
        end

        // Held jump reaches 42
        cyc(0, 1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            want($sformatf("hold_t%0d", i + 1), hold_tbl[i]);
            cyc(1, 1, 0, 0);
            got(bus.player_position);
        end
        for (int n = 0; n < 30 && bus.jumping; n++) cyc(1, 0, 0, 0);
        want("hold_landed", 0); want("hold_land_pos", 0);
        cyc(0, 0, 0, 0);
        got(bus.jumping); got(bus.player_position);

        // Double jump at the apex
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 7; i++) cyc(1, 0, 0, 0);
        want("dj_apex", 28);
        cyc(0, 0, 0, 0);
        got(bus.player_position);
        want("dj_pulse", 1); want("dj_jl", 0);
        cyc(0, 1, 0, 0);
        got(bus.jump_pulse); got(bus.jumps_left);
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            want($sformatf("dj_t%0d", i + 1), dj_tbl[i]);
            cyc(1, 0, 0, 0);
            got(bus.player_position);
        end
        want("third_nopulse", 0); want("third_jl", 0);
        cyc(0, 1, 0, 0);
        got(bus.jump_pulse); got(bus.jumps_left);
        cyc(0, 0, 0, 0);

        // Fast-fall with button_down held
        for (int i = 0; i < 10; i++) begin
            want($sformatf("ff_t%0d", i + 1), ff_tbl[i]);
            if (i == 0) want("air_noduck", 0);
            if (i == 9) begin
                want("ff_land_air", 0); want("ff_land_jl", 2); want("ff_land_duck", 1);
            end
            cyc(1, 0, 1, 0);
            got(bus.player_position);
            if (i == 0) got(bus.ducking);
            if (i == 9) begin
                got(bus.jumping); got(bus.jumps_left); got(bus.ducking);
            end
        end

        // Crash on a tick at 22
        cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
        want("crash_over", 1); want("crash_pos", 22); want("crash_air", 0);
        cyc(1, 0, 0, 1);
        got(bus.game_over_pulse); got(bus.player_position); got(bus.jumping);
        want("crash_once", 0); want("dead_pos_a", 22);
        cyc(1, 0, 0, 1);
        got(bus.game_over_pulse); got(bus.player_position);
        want("dead_pos_b", 22); want("dead_noduck", 0);
        cyc(1, 0, 1, 0);
        got(bus.player_position); got(bus.ducking);
        want("restart_pulse", 1); want("restart_pos", 0); want("restart_jl", 2);
        want("restart_air", 0); want("restart_noover", 0);
        cyc(0, 1, 0, 1);
        got(bus.game_start_pulse); got(bus.player_position); got(bus.jumps_left);
        got(bus.jumping); got(bus.game_over_pulse);
        want("restart_once", 0);
        cyc(0, 0, 0, 0);
        got(bus.game_start_pulse);

        // Jump on the landing tick keeps the player airborne at 0
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 14; i++) cyc(1, 0, 0, 0);
        want("ov_pos", 0); want("ov_air", 1); want("ov_pulse", 1); want("ov_jl", 0);
        cyc(1, 1, 0, 0);
        got(bus.player_position); got(bus.jumping); got(bus.jump_pulse); got(bus.jumps_left);
        cyc(0, 0, 0, 0);
        want("ov_next", 7);
        cyc(1, 0, 0, 0);
        got(bus.player_position);

        // Asynchronous reset mid-air
        want("mrst_pos", 0); want("mrst_air", 0); want("mrst_jl", 2);
        reset_n = 1'b0;
        #1;
        got(bus.player_position); got(bus.jumping); got(bus.jumps_left);
        reset_n = 1'b1;

        // Narrow height: ceiling clamp
        cyc4(0, 1);
        cyc4(0, 0);
        want("p4_pulse", 1);
        cyc4(0, 1);
        got(bus4.jump_pulse);
        cyc4(0, 0);
        for (int i = 0; i < 5; i++) begin
            want($sformatf("p4_t%0d", i + 1), p4_tbl[i]);
            cyc4(1, 0);
            got(bus4.player_position);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
